// File: rtl/ata_sector_sequencer.sv
// ata_sector_sequencer: polls ATA status and moves whole sectors between the PIO engine and a word FIFO
module ata_sector_sequencer #(
  parameter logic [15:0] POLL_LIMIT   = 16'd50000,
  parameter logic [8:0]  SECTOR_WORDS = 9'd256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        dir,
  input  logic [7:0]  sector_count,
  output logic        pio_req,
  output logic        pio_wr,
  output logic [3:0]  pio_addr,
  output logic [15:0] pio_wdata,
  input  logic [15:0] pio_rdata,
  input  logic        pio_done,
  output logic        fifo_push,
  output logic [15:0] fifo_wdata,
  input  logic        fifo_full,
  output logic        fifo_pop,
  input  logic [15:0] fifo_rdata,
  input  logic        fifo_empty,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [8:0]  sectors_left
);
  typedef enum logic [2:0] {IDLE, POLL, CHECK, XFER, XWAIT, NEXT, FIN, ERR} state_t;
  state_t      r_state, w_next;
  logic        r_dir;
  logic [15:0] r_poll_cnt;
  logic [8:0]  r_word_cnt;
  logic [8:0]  r_sectors_left;
  logic [7:0]  r_status;
  logic        r_pio_req;
  logic        r_pio_wr;
  logic [3:0]  r_pio_addr;
  logic [15:0] r_pio_wdata;
  logic        w_ack;
  logic        w_issue;
  logic        w_push;
  logic        w_pop;
  logic        w_not_ready;
  // a completion pulse only counts while our own request is outstanding
  assign w_ack       = pio_done & r_pio_req;
  assign w_not_ready = r_status[7] | ~r_status[3];
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  // next state plus the single-cycle FIFO strobes and request-issue decision
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    case (r_state)
      IDLE:  w_next = start ? POLL : IDLE;
      POLL:  w_next = w_ack ? CHECK : POLL;
      CHECK: w_next = r_status[0] ? ERR : !w_not_ready ? XFER : (r_poll_cnt == POLL_LIMIT) ? ERR : POLL;
      XFER: begin
        w_pop  = r_dir & ~fifo_empty;
        w_next = (r_dir ? ~fifo_empty : ~fifo_full) ? XWAIT : XFER;
      end
      XWAIT: begin
        w_push = w_ack & ~r_dir;
        w_next = !w_ack ? XWAIT : (r_word_cnt + 9'd1 == SECTOR_WORDS) ? NEXT : XFER;
      end
      NEXT:    w_next = (r_sectors_left == 9'd1) ? FIN : POLL;
      default: w_next = IDLE;
    endcase
    w_issue = (w_next == POLL || w_next == XWAIT) && (w_next != r_state);
  end
  // register-access request: raised on entry to POLL/XWAIT, fields frozen until the completion pulse
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_pio_req   <= 1'b0;
      r_pio_wr    <= 1'b0;
      r_pio_addr  <= 4'd0;
      r_pio_wdata <= 16'd0;
    end else if (w_issue) begin
      r_pio_req  <= 1'b1;
      r_pio_wr   <= (w_next == XWAIT) & r_dir;
      r_pio_addr <= (w_next == POLL) ? 4'b0111 : 4'b0000;
      if (w_next == XWAIT && r_dir) r_pio_wdata <= fifo_rdata;
    end else if (w_ack) begin
      r_pio_req <= 1'b0;
    end
  // transfer bookkeeping: direction, status snapshot and the three counters
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_dir          <= 1'b0;
      r_poll_cnt     <= 16'd0;
      r_word_cnt     <= 9'd0;
      r_sectors_left <= 9'd0;
      r_status       <= 8'd0;
    end else begin
      if (r_state == IDLE && start) begin
        r_dir          <= dir;
        r_sectors_left <= (sector_count == 8'd0) ? 9'd256 : {1'b0, sector_count};
        r_poll_cnt     <= 16'd0;
      end
      if (r_state == POLL && w_ack) begin
        r_status   <= pio_rdata[7:0];
        r_poll_cnt <= r_poll_cnt + {15'd0, ~&r_poll_cnt};
      end
      if (r_state == CHECK && w_next == XFER) r_word_cnt <= 9'd0;
      if (r_state == XWAIT && w_ack) r_word_cnt <= r_word_cnt + {8'd0, ~&r_word_cnt};
      if (r_state == NEXT) begin
        r_sectors_left <= r_sectors_left - {8'd0, r_sectors_left != 9'd0};
        r_poll_cnt     <= 16'd0;
      end
    end
  assign pio_req      = r_pio_req;
  assign pio_wr       = r_pio_wr;
  assign pio_addr     = r_pio_addr;
  assign pio_wdata    = r_pio_wdata;
  assign fifo_push    = w_push;
  assign fifo_wdata   = pio_rdata;
  assign fifo_pop     = w_pop;
  assign busy         = (r_state != IDLE) && (r_state != FIN) && (r_state != ERR);
  assign done         = (r_state == FIN) || (r_state == ERR);
  assign error        = r_state == ERR;
  assign sectors_left = r_sectors_left;
endmodule

// File: tb/tb_ata_sector_sequencer.sv
// tb_ata_sector_sequencer: directed scenarios with a randomized PIO device and FIFO model
module tb_ata_sector_sequencer;
  logic        clk = 0;
  logic        reset = 1;
  logic        start = 0;
  logic        dir = 0;
  logic [7:0]  sector_count = 0;
  logic        pio_req, pio_wr;
  logic [3:0]  pio_addr;
  logic [15:0] pio_wdata;
  logic [15:0] pio_rdata = 0;
  logic        pio_done = 0;
  logic        fifo_push, fifo_pop;
  logic [15:0] fifo_wdata;
  logic        fifo_full = 0;
  logic [15:0] fifo_rdata = 0;
  logic        fifo_empty = 1;
  logic        busy, done, error;
  logic [8:0]  sectors_left;
  int n_cmp = 0;
  int n_err = 0;
  int n_stat = 0;
  int n_rd = 0;
  int n_wr = 0;
  logic [7:0]  status_q[$];
  logic [7:0]  status_dflt = 8'h58;
  logic [15:0] exp_push[$];
  logic [15:0] got_push[$];
  logic [15:0] wq[$];
  logic [15:0] exp_wr[$];
  logic [15:0] got_wr[$];
  logic        rs_w;
  logic [3:0]  rs_a;
  logic [15:0] rs_d;
  int          rs_lat;
  bit          rs_live;
  bit          rs_pulsed = 0;
  bit          mon_pop;
  logic [15:0] mon_tmp;
  bit          ok;

  always #5 clk = ~clk;

  ata_sector_sequencer #(.POLL_LIMIT(16'd4), .SECTOR_WORDS(9'd256)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .sector_count(sector_count),
    .pio_req(pio_req), .pio_wr(pio_wr), .pio_addr(pio_addr), .pio_wdata(pio_wdata),
    .pio_rdata(pio_rdata), .pio_done(pio_done),
    .fifo_push(fifo_push), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
    .fifo_pop(fifo_pop), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
    .busy(busy), .done(done), .error(error), .sectors_left(sectors_left)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  function automatic int push_bad();
    int b = (got_push.size() == exp_push.size()) ? 0 : 1;
    for (int i = 0; i < got_push.size() && i < exp_push.size(); i++) if (got_push[i] !== exp_push[i]) b++;
    return b;
  endfunction

  function automatic int wr_bad();
    int b = (got_wr.size() == exp_wr.size()) ? 0 : 1;
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++) if (got_wr[i] !== exp_wr[i]) b++;
    return b;
  endfunction

  task automatic clr();
    n_stat = 0; n_rd = 0; n_wr = 0;
    exp_push.delete(); got_push.delete(); got_wr.delete(); exp_wr.delete(); status_q.delete();
  endtask

  task automatic go(input logic d, input logic [7:0] sc);
    @(negedge clk); start = 1; dir = d; sector_count = sc;
    @(negedge clk); start = 0;
  endtask

  task automatic finish_ok(input string tag, input int bound, input logic exp_err, input logic [8:0] exp_left);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin @(negedge clk); seen = done; end
    chk({tag, "_done"}, seen, 1);
    chk({tag, "_err"}, error, exp_err);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_left"}, sectors_left, exp_left);
    @(negedge clk);
    chk({tag, "_pulse"}, {done, error}, 0);
  endtask

  task automatic wait_push(input int n, input int bound, output bit got);
    got = 0;
    for (int i = 0; i < bound && !got; i++) begin @(negedge clk); got = got_push.size() >= n; end
  endtask

  // PIO device: random latency, status from a script, random read data, logs writes, stray pulses when idle
  initial forever begin
    @(posedge clk); #1;
    pio_done = 0;
    if (rs_pulsed) chk("req_drop", pio_req, 0);
    rs_pulsed = 0;
    if (reset && pio_req) begin
      rs_w = pio_wr; rs_a = pio_addr; rs_d = pio_wdata;
      rs_lat = $urandom_range(0, 3); rs_live = 1;
      for (int i = 0; i < rs_lat && rs_live; i++) begin
        @(posedge clk); #1;
        rs_live = reset && pio_req;
        if (rs_live) chk("pio_hold", {pio_wr, pio_addr, pio_wdata}, {rs_w, rs_a, rs_d});
      end
      if (rs_live) begin
        if (!rs_w && rs_a == 4'b0111) begin
          n_stat++;
          pio_rdata = {8'h00, (status_q.size() != 0) ? status_q.pop_front() : status_dflt};
        end else if (!rs_w && rs_a == 4'b0000) begin
          n_rd++;
          pio_rdata = 16'($urandom);
          exp_push.push_back(pio_rdata);
        end else if (rs_w && rs_a == 4'b0000) begin
          n_wr++;
          got_wr.push_back(rs_d);
        end else chk("pio_access", {rs_w, rs_a}, 5'h07);
        pio_done = 1; rs_pulsed = 1;
      end
    end else if (reset && $urandom_range(0, 7) == 0) begin
      pio_rdata = 16'($urandom);
      pio_done = 1;
    end
  end

  // FIFO model and strobe monitor: sample mid-cycle, advance the write queue just after the edge
  initial forever begin
    @(negedge clk);
    mon_pop = fifo_pop;
    if (fifo_push || fifo_pop) begin
      chk("push_pop_excl", {fifo_push, fifo_pop}, fifo_push ? 2'b10 : 2'b01);
      if (fifo_push) begin chk("push_full", fifo_full, 0); got_push.push_back(fifo_wdata); end
      if (fifo_pop) chk("pop_empty", fifo_empty, 0);
    end
    @(posedge clk); #1;
    if (mon_pop && wq.size() != 0) mon_tmp = wq.pop_front();
    fifo_empty = wq.size() == 0;
    fifo_rdata = (wq.size() != 0) ? wq[0] : 16'h0;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3 reset = 0;
    #1;
    chk("rst_pio", {pio_req, pio_wr, pio_addr, pio_wdata}, 0);
    chk("rst_fifo", {fifo_push, fifo_pop}, 0);
    chk("rst_flags", {busy, done, error}, 0);
    chk("rst_left", sectors_left, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    // one sector read, ready on the first poll
    clr();
    go(0, 8'd1);
    chk("r1_busy", busy, 1);
    chk("r1_left", sectors_left, 1);
    finish_ok("r1", 5000, 0, 0);
    chk("r1_stat", n_stat, 1);
    chk("r1_rd", n_rd, 256);
    chk("r1_wr", n_wr, 0);
    chk("r1_order", push_bad(), 0);
    // busy and no-DRQ statuses force re-polls before the data phase
    clr();
    status_q = '{8'hD0, 8'h50};
    go(0, 8'd1);
    finish_ok("rp", 5000, 0, 0);
    chk("rp_stat", n_stat, 3);
    chk("rp_order", push_bad(), 0);
    // two sector write from a preloaded FIFO, with a start pulse mid-transfer
    clr();
    for (int i = 0; i < 512; i++) begin mon_tmp = 16'($urandom); wq.push_back(mon_tmp); exp_wr.push_back(mon_tmp); end
    repeat (2) @(negedge clk);
    go(1, 8'd2);
    chk("w2_left0", sectors_left, 2);
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin @(negedge clk); ok = got_wr.size() >= 20; end
    chk("w2_progress", ok, 1);
    go(0, 8'd9);
    chk("w2_ignored_left", sectors_left, 2);
    chk("w2_ignored_busy", busy, 1);
    finish_ok("w2", 10000, 0, 0);
    chk("w2_stat", n_stat, 2);
    chk("w2_wr", n_wr, 512);
    chk("w2_rd", n_rd, 0);
    chk("w2_order", wr_bad(), 0);
    chk("w2_popped", wq.size(), 0);
    // drive stays busy: poll limit reached
    clr();
    status_dflt = 8'h80;
    go(0, 8'd1);
    finish_ok("tmo", 500, 1, 1);
    chk("tmo_stat", n_stat, 4);
    chk("tmo_rd", n_rd, 0);
    status_dflt = 8'h58;
    // drive reports an error on the first poll
    clr();
    status_q = '{8'h51};
    go(0, 8'd1);
    finish_ok("derr", 500, 1, 1);
    chk("derr_stat", n_stat, 1);
    chk("derr_rd", n_rd + n_wr, 0);
    // FIFO full stall after word 10
    clr();
    go(0, 8'd1);
    wait_push(10, 2000, ok);
    chk("st_reach10", ok, 1);
    fifo_full = 1;
    for (int i = 0; i < 20; i++) begin @(negedge clk); chk("st_req_low", pio_req, 0); end
    chk("st_held", got_push.size(), 10);
    fifo_full = 0;
    finish_ok("st", 5000, 0, 0);
    chk("st_rd", n_rd, 256);
    chk("st_order", push_bad(), 0);
    // sector_count 0 means 256; reset mid-transfer then a clean run
    clr();
    go(0, 8'd0);
    chk("s0_left", sectors_left, 256);
    wait_push(100, 3000, ok);
    chk("s0_reach100", ok, 1);
    reset = 0;
    #1;
    chk("ar_pio", {pio_req, pio_wr, pio_addr, pio_wdata}, 0);
    chk("ar_fifo", {fifo_push, fifo_pop}, 0);
    chk("ar_flags", {busy, done, error}, 0);
    chk("ar_left", sectors_left, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    clr();
    go(0, 8'd1);
    chk("pr_left", sectors_left, 1);
    finish_ok("pr", 5000, 0, 0);
    chk("pr_stat", n_stat, 1);
    chk("pr_rd", n_rd, 256);
    chk("pr_order", push_bad(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ata_sector_sequencer.md
ATA_SECTOR_SEQUENCER -- requirements
Module: ata_sector_sequencer

Interface
REQ-001 SHALL have parameter POLL_LIMIT, default 16'd50000, max status polls per sector before timeout.
REQ-002 SHALL have parameter SECTOR_WORDS, default 9'd256, 16-bit words per sector.
REQ-003 SHALL have: clk  input  1  system clock; reset, asynchronous, active-low; clock clk.
REQ-004 SHALL have: reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have: start  input  1  one-cycle pulse, begins a transfer when idle.
REQ-006 SHALL have: dir  input  1  0 = read from drive, 1 = write to drive; sampled on start.
REQ-007 SHALL have: sector_count  input  8  sectors to move; sampled on start; 0 means 256.
REQ-008 SHALL have: pio_req / pio_wr / pio_addr  output  1/1/4  register-access request to PIO engine; addr[3] = CS1 select, addr[2:0] = DA.
REQ-009 SHALL have: pio_wdata  output  16  write data; pio_rdata  input  16  read data; pio_done  input  1  one-cycle access-complete pulse.
REQ-010 SHALL have: fifo_push / fifo_wdata  output  1/16  read-path buffer write; fifo_full  input  1.
REQ-011 SHALL have: fifo_pop  output  1  write-path buffer read; fifo_rdata  input  16  (valid same cycle); fifo_empty  input  1.
REQ-012 SHALL have: busy, done, error  output  1 each; sectors_left  output  9.

Function
REQ-013 SHALL use states IDLE, POLL, CHECK, XFER, XWAIT, NEXT, FIN, ERR.
REQ-014 IDLE: start=1 -> latch dir, sectors_left = (sector_count==0 ? 256 : sector_count), poll_cnt=0, enter POLL; busy=1 next cycle.
REQ-015 POLL: issue read of status register (pio_addr=4'b0111, pio_wr=0); on pio_done capture pio_rdata[7:0] as status, poll_cnt+1, enter CHECK.
REQ-016 CHECK: status[0] (ERR) = 1 -> ERR; status[7] (BSY) = 1 or status[3] (DRQ) = 0 -> POLL, unless poll_cnt == POLL_LIMIT -> ERR; else word_cnt=0, enter XFER.
REQ-017 XFER read: wait while fifo_full; then request data register read (addr 4'b0000); enter XWAIT.
REQ-018 XFER write: wait while fifo_empty; then pulse fifo_pop, register fifo_rdata into pio_wdata, request write to addr 4'b0000; enter XWAIT.
REQ-019 XWAIT: on pio_done -> read path pulses fifo_push with fifo_wdata=pio_rdata same cycle; word_cnt+1; word_cnt reaching SECTOR_WORDS -> NEXT, else XFER.
REQ-020 NEXT: sectors_left-1; result 0 -> FIN; else poll_cnt=0, POLL.
REQ-021 FIN: done=1 for exactly one cycle, busy=0, return to IDLE. ERR: error=1 and done=1 for one cycle, busy=0, return to IDLE.
REQ-022 Handshake: pio_req SHALL rise on state entry, hold pio_wr/pio_addr/pio_wdata stable while high, drop the cycle after pio_done; at most one outstanding access; pio_done while pio_req=0 ignored.
REQ-023 fifo_push and fifo_pop SHALL never assert in the same cycle, never push while fifo_full, never pop while fifo_empty.
REQ-024 start while busy SHALL be ignored; start and pio_done in the same cycle SHALL not corrupt the active access.
REQ-025 poll_cnt 16-bit, word_cnt 9-bit, sectors_left 9-bit, all non-wrapping within a transfer.

Reset
REQ-026 reset=0 SHALL asynchronously force IDLE, pio_req=0, pio_wr=0, pio_addr=0, pio_wdata=0, fifo_push=0, fifo_pop=0, busy=0, done=0, error=0, sectors_left=0, all counters 0.
REQ-027 reset asserted mid-access SHALL abort immediately; first start after release SHALL begin a fresh transfer with no residual state.

Verification
REQ-028 Read 1 sector, status 0x58 on first poll -> 1 status read, 256 data reads, 256 fifo_push in order, done pulse, sectors_left=0, error=0.
REQ-029 Write 2 sectors, FIFO preloaded 512 words -> 2 status polls, 512 writes with pio_wdata matching FIFO order, 512 pops, done=1.
REQ-030 Status 0x80 returned indefinitely, POLL_LIMIT=4 -> exactly 4 status reads, then error=1 and done=1 same cycle, busy=0.
REQ-031 Status 0x51 (ERR) on first poll -> no data access, error pulse next cycles, return to IDLE.
REQ-032 Read with fifo_full held 20 cycles after word 10 -> pio_req stays low, resumes at word 11, no lost/duplicate words.
REQ-033 sector_count=0 -> sectors_left=256 after start; reset pulse at word 100 -> all outputs at reset values, next start runs clean.
